systolic_a_skew: RTL and testbench

//   Input skew buffer directly upstream of the tpumac systolic array.

---
 rtl/systolic_a_skew.sv | 150 +++++++++++++++
 tb/tb_systolic_a_skew.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_a_skew.sv
// Input skew buffer for the systolic array: stores one DIM x DIM A matrix and
// streams it with row i delayed by i cycles so the wavefront meets each MAC row.
module systolic_a_skew #(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned DIM     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     wr_en,
    input  logic [$clog2(DIM)-1:0]   wr_row,
    input  logic [DIM*BITS_AB-1:0]   wr_data,
    input  logic                     start,
    output logic [DIM*BITS_AB-1:0]   a_out,
    output logic                     valid,
    output logic                     last,
    output logic                     busy
);

    localparam int unsigned RW       = $clog2(DIM);
    localparam int unsigned CW       = $clog2(2*DIM-1);
    localparam int unsigned BUS_W    = DIM*BITS_AB;
    localparam int unsigned LAST_CNT = 2*DIM-2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   at_last;

    logic [BITS_AB-1:0]     mem [DIM][DIM];

    logic [BUS_W-1:0]       lanes_c;
    logic [BUS_W-1:0]       a_nxt;
    logic                   valid_nxt;
    logic                   last_nxt;

    assign at_last = (cnt == CW'(LAST_CNT));
    assign busy    = (state == STREAM);

    // Matrix storage: written only while idle, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(DIM); r++) begin
                for (int c = 0; c < int'(DIM); c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (state == IDLE && wr_en) begin
            for (int c = 0; c < int'(DIM); c++) begin
                mem[wr_row][c] <= wr_data[c*BITS_AB +: BITS_AB];
            end
        end
    end

    // Diagonal band select: lane i reads column cnt-i of row i, zero outside.
    for (genvar i = 0; i < int'(DIM); i++) begin : g_lane
        logic [CW:0] diff;
        logic        in_band;

        assign diff    = {1'b0, cnt} - (CW+1)'(i);
        assign in_band = !diff[CW] && (diff < (CW+1)'(DIM));
        assign lanes_c[i*BITS_AB +: BITS_AB] = in_band ? mem[i][diff[RW-1:0]]
                                                       : {BITS_AB{1'b0}};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; en gates only stream progress, not the start handshake.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                    cnt_nxt   = '0;
                end
            end
            STREAM: begin
                if (en) begin
                    if (at_last) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output next-value logic; a stalled stream holds its current beat.
    always_comb begin
        a_nxt     = a_out;
        valid_nxt = valid;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                a_nxt     = '0;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
            STREAM: begin
                if (en) begin
                    a_nxt     = lanes_c;
                    valid_nxt = 1'b1;
                    last_nxt  = at_last;
                end
            end
            default: begin
                a_nxt     = '0;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // Registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_out <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else begin
            a_out <= a_nxt;
            valid <= valid_nxt;
            last  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_systolic_a_skew.sv
// Directed bench for systolic_a_skew at DIM=4, BITS_AB=8: beat tables plus
// stall, ignored-command, reset-abort and write-with-start sequences.
module tb_systolic_a_skew;

    localparam int unsigned DIM     = 4;
    localparam int unsigned BITS_AB = 8;
    localparam int unsigned W       = DIM*BITS_AB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          wr_en;
    logic [1:0]    wr_row;
    logic [W-1:0]  wr_data;
    logic          start;
    logic [W-1:0]  a_out;
    logic          valid;
    logic          last;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic        v;
        logic        l;
        logic        b;
    } beat_t;

    beat_t t1 [8];
    beat_t t2 [8];

    always #5 clk = ~clk;

    systolic_a_skew #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .start   (start),
        .a_out   (a_out),
        .valid   (valid),
        .last    (last),
        .busy    (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input beat_t e);
        chk($sformatf("%s a_out", tag), a_out, e.a);
        chk($sformatf("%s valid", tag), 32'(valid), 32'(e.v));
        chk($sformatf("%s last", tag), 32'(last), 32'(e.l));
        chk($sformatf("%s busy", tag), 32'(busy), 32'(e.b));
    endtask

    task automatic load_rows(input logic [31:0] r0, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] r3);
        logic [31:0] rows [4];
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
        for (int r = 0; r < 4; r++) begin
            wr_en   = 1'b1;
            wr_row  = 2'(r);
            wr_data = rows[r];
            tick();
        end
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic load_t1();
        load_rows(32'h04030201, 32'h14131211, 32'h24232221, 32'h34333231);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;

        // Expected beats for mem[i][j] = 16*i+j+1 (lane0 in the low byte).
        t1[0] = '{32'h00000001, 1'b1, 1'b0, 1'b1};
        t1[1] = '{32'h00001102, 1'b1, 1'b0, 1'b1};
        t1[2] = '{32'h00211203, 1'b1, 1'b0, 1'b1};
        t1[3] = '{32'h31221304, 1'b1, 1'b0, 1'b1};
        t1[4] = '{32'h32231400, 1'b1, 1'b0, 1'b1};
        t1[5] = '{32'h33240000, 1'b1, 1'b0, 1'b1};
        t1[6] = '{32'h34000000, 1'b1, 1'b1, 1'b0};
        t1[7] = '{32'h00000000, 1'b0, 1'b0, 1'b0};
        // Row 2 = {-128, 127, -1, 0}; lane 2 carries it on beats 3..6.
        t2[0] = '{32'h00000000, 1'b1, 1'b0, 1'b1};
        t2[1] = '{32'h00000000, 1'b1, 1'b0, 1'b1};
        t2[2] = '{32'h00800000, 1'b1, 1'b0, 1'b1};
        t2[3] = '{32'h007F0000, 1'b1, 1'b0, 1'b1};
        t2[4] = '{32'h00FF0000, 1'b1, 1'b0, 1'b1};
        t2[5] = '{32'h00000000, 1'b1, 1'b0, 1'b1};
        t2[6] = '{32'h00000000, 1'b1, 1'b1, 1'b0};
        t2[7] = '{32'h00000000, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; en = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0;
        tick();
        tick();
        chk_beat("reset", '{32'h0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;

        // Test 1: full diagonal stream.
        load_t1();
        do_start();
        chk("t1 start busy", 32'(busy), 32'd1);
        chk("t1 start valid", 32'(valid), 32'd0);
        for (int b = 0; b < 8; b++) begin
            tick();
            chk_beat($sformatf("t1 beat%0d", b+1), t1[b]);
        end

        // Test 2: signed extremes pass through unmodified.
        load_rows(32'h0, 32'h0, 32'h00FF7F80, 32'h0);
        do_start();
        for (int b = 0; b < 8; b++) begin
            tick();
            chk_beat($sformatf("t2 beat%0d", b+1), t2[b]);
        end

        // Test 3: three stall cycles after beat 2.
        load_t1();
        do_start();
        tick(); chk_beat("t3 beat1", t1[0]);
        tick(); chk_beat("t3 beat2", t1[1]);
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk_beat($sformatf("t3 stall%0d", s), t1[1]);
        end
        en = 1'b1;
        tick(); chk_beat("t3 beat3", t1[2]);
        n = 0;
        for (int i = 0; i < 30 && !last; i++) begin
            tick();
            n++;
        end
        chk("t3 edges start->last", 32'(6 + n), 32'd10);
        chk_beat("t3 final", t1[6]);

        // Test 4: start and wr_en during STREAM are ignored.
        do_start();
        tick(); chk_beat("t4 beat1", t1[0]);
        start = 1'b1; wr_en = 1'b1; wr_row = 2'd0; wr_data = 32'hAAAAAAAA;
        tick(); chk_beat("t4 beat2", t1[1]);
        start = 1'b0; wr_en = 1'b0; wr_data = '0;
        for (int b = 2; b < 8; b++) begin
            tick();
            chk_beat($sformatf("t4 beat%0d", b+1), t1[b]);
        end
        tick(); chk_beat("t4 no restart", t1[7]);
        do_start();
        tick(); chk_beat("t4 restream beat1", t1[0]);
        tick(); chk_beat("t4 restream beat2", t1[1]);
        for (int i = 0; i < 30 && busy; i++) tick();
        tick();

        // Test 5: reset in the middle of a stream, then an all-zero stream.
        do_start();
        tick(); tick();
        chk_beat("t5 beat2", t1[1]);
        rst_n = 1'b0;
        tick();
        chk_beat("t5 after reset", '{32'h0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        tick();
        chk_beat("t5 idle", '{32'h0, 1'b0, 1'b0, 1'b0});
        do_start();
        for (int b = 0; b < 7; b++) begin
            tick();
            chk_beat($sformatf("t5 zero beat%0d", b+1), '{32'h0, 1'b1, 1'(b == 6), 1'(b != 6)});
        end
        tick();

        // Test 6: write row 1 and start in the same idle cycle.
        load_t1();
        wr_en = 1'b1; wr_row = 2'd1; wr_data = 32'h44332299; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0; wr_data = '0;
        tick(); chk_beat("t6 beat1", t1[0]);
        tick(); chk_beat("t6 beat2", '{32'h00009902, 1'b1, 1'b0, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
